// File: rtl/p2s_arbiter_if.sv
// Bus between the two display requesters, the p2s_arbiter and the serial LED shifter.
interface p2s_arbiter_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 req0;
    logic                 req1;
    logic [BIT_WIDTH-1:0] data0;
    logic [BIT_WIDTH-1:0] data1;
    logic                 ack0;
    logic                 ack1;
    logic                 p2s_start;
    logic [BIT_WIDTH-1:0] p2s_data;
    logic                 p2s_latch;
    logic                 busy;
    logic                 owner;

    modport master (
        output req0, req1, data0, data1,
        input  ack0, ack1, p2s_start, p2s_data, p2s_latch, busy, owner
    );

    modport slave (
        input  req0, req1, data0, data1,
        output ack0, ack1, p2s_start, p2s_data, p2s_latch, busy, owner
    );
endinterface

// File: rtl/p2s_arbiter.sv
// Round-robin sharing of one P2S LED shifter between two requesters.
// Define P2S_ARB_REFRESH_EN to compile in periodic re-sending of the last word.
module p2s_arbiter #(
    parameter int BIT_WIDTH      = 16,
    parameter int REFRESH_CYCLES = 1000000
) (
    input logic          clk,
    input logic          rstn,
    p2s_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam int               CNT_W    = $clog2(BIT_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH);

    if (REFRESH_CYCLES < BIT_WIDTH + 4) begin : g_cfg_check
        $error("p2s_arbiter: REFRESH_CYCLES must be at least BIT_WIDTH+4");
    end

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] shadow_q, shadow_d;
    logic                 valid_q, valid_d;
    logic                 owner_q, owner_d;
    logic                 req_txn_q, req_txn_d;
    logic                 start_q, start_d;
    logic                 latch_q, latch_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 busy_q, busy_d;

    logic grant0;
    logic grant1;
    logic refresh_due;

    // A lone request wins; on a tie the requester that is not the owner wins.
    assign grant0 = bus.req0 & (~bus.req1 | owner_q);
    assign grant1 = bus.req1 & (~bus.req0 | ~owner_q);

`ifdef P2S_ARB_REFRESH_EN
    localparam int               TMR_W    = $clog2(REFRESH_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    // Restarts on every LOAD, so a request that wins over a due refresh also restarts it.
    always_comb begin
        timer_d = timer_q;
        if (state_d == ST_LOAD) begin
            timer_d = '0;
        end else if (timer_q < TMR_LAST) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign refresh_due = (timer_q >= TMR_LAST) & valid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign refresh_due = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        valid_d   = valid_q;
        owner_d   = owner_q;
        req_txn_d = req_txn_q;

        case (state_q)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    state_d   = ST_LOAD;
                    owner_d   = grant1;
                    shadow_d  = grant1 ? bus.data1 : bus.data0;
                    req_txn_d = 1'b1;
                end else if (refresh_due) begin
                    state_d   = ST_LOAD;
                    req_txn_d = 1'b0;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they appear registered in that state.
        start_d = (state_d == ST_LOAD);
        latch_d = (state_d == ST_LATCH);
        busy_d  = (state_d != ST_IDLE);
        ack0_d  = latch_d & req_txn_q & ~owner_q;
        ack1_d  = latch_d & req_txn_q & owner_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            valid_q   <= 1'b0;
            owner_q   <= 1'b1;
            req_txn_q <= 1'b0;
            start_q   <= 1'b0;
            latch_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            valid_q   <= valid_d;
            owner_q   <= owner_d;
            req_txn_q <= req_txn_d;
            start_q   <= start_d;
            latch_q   <= latch_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.p2s_start = start_q;
    assign bus.p2s_data  = shadow_q;
    assign bus.p2s_latch = latch_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_p2s_arbiter.sv
// Scoreboard bench for p2s_arbiter; honours P2S_ARB_REFRESH_EN (refresh period 40 when defined).
module tb_p2s_arbiter;

    localparam int BW = 16;
`ifdef P2S_ARB_REFRESH_EN
    localparam int REFRESH = 40;
`else
    localparam int REFRESH = 1000000;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    p2s_arbiter_if #(.BIT_WIDTH(BW)) bus ();

    p2s_arbiter #(.BIT_WIDTH(BW), .REFRESH_CYCLES(REFRESH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          owner;
        logic [BW-1:0] data;
        logic          refresh;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned n_start = 0;
    int unsigned n_latch = 0;
    int unsigned n_ack1 = 0;
    int unsigned last_start = 0;
    int unsigned prev_start = 0;
    int unsigned last_latch = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, latched words scored in order.
    always @(negedge clk) begin
        if (bus.ack1) n_ack1++;
        if (bus.p2s_start) begin
            prev_start = last_start;
            last_start = cyc;
            n_start++;
            if (exp_q.size() != 0) check_eq("start_data", bus.p2s_data, exp_q[0].data);
            else check_eq("start_without_request", exp_q.size(), 1);
        end
        if (bus.p2s_latch) begin
            n_latch++;
            last_latch = cyc;
            if (exp_q.size() == 0) begin
                check_eq("latch_without_request", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("latch_data", bus.p2s_data, mon_e.data);
                check_eq("latch_owner", bus.owner, mon_e.owner);
                check_eq("ack0", bus.ack0, !mon_e.refresh && !mon_e.owner);
                check_eq("ack1", bus.ack1, !mon_e.refresh && mon_e.owner);
                check_eq("start_to_latch", last_latch - last_start, BW + 2);
            end
        end else if (bus.ack0 || bus.ack1) begin
            check_eq("stray_ack", {bus.ack0, bus.ack1}, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic owner, input logic [BW-1:0] data, input logic refresh);
        exp_t e;
        e.owner   = owner;
        e.data    = data;
        e.refresh = refresh;
        exp_q.push_back(e);
    endtask

    task automatic wait_latches(input int unsigned target, input int unsigned budget, input bit auto_drop);
        int unsigned k = 0;
        while (n_latch < target && k < budget) begin
            tick();
            k++;
            if (auto_drop && bus.ack0) bus.req0 = 1'b0;
            if (auto_drop && bus.ack1) bus.req1 = 1'b0;
        end
        if (n_latch < target) check_eq("latch_timeout", n_latch, target);
    endtask

    int unsigned c;
    int unsigned saved;

    initial begin
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;
        repeat (3) tick();
        check_eq("rst_ack0", bus.ack0, 0);
        check_eq("rst_ack1", bus.ack1, 0);
        check_eq("rst_start", bus.p2s_start, 0);
        check_eq("rst_latch", bus.p2s_latch, 0);
        check_eq("rst_data", bus.p2s_data, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_owner", bus.owner, 1);
        rstn = 1'b1;
        tick();

        // Single request: start at +1, latch/ack at +19, idle at +20
        c = cyc;
        bus.data0 = 16'hA5C3;
        bus.req0  = 1'b1;
        push(1'b0, 16'hA5C3, 1'b0);
        wait_latches(n_latch + 1, 40, 1'b1);
        check_eq("t1_start_cycle", last_start - c, 1);
        check_eq("t1_latch_cycle", last_latch - c, 19);
        tick();
        check_eq("t1_busy_after", bus.busy, 0);

        // Fresh reset so owner is 1 again: tie goes to req0, req1 follows 20 cycles later
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        bus.data0 = 16'h1111;
        bus.data1 = 16'h2222;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        push(1'b0, 16'h1111, 1'b0);
        push(1'b1, 16'h2222, 1'b0);
        wait_latches(n_latch + 2, 60, 1'b1);
        check_eq("t2_start_spacing", last_start - prev_start, 20);

        // Both held: grants alternate 0,1,0,1
        bus.data0 = 16'h3333;
        bus.data1 = 16'h4444;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        push(1'b0, 16'h3333, 1'b0);
        push(1'b1, 16'h4444, 1'b0);
        push(1'b0, 16'h3333, 1'b0);
        push(1'b1, 16'h4444, 1'b0);
        wait_latches(n_latch + 4, 120, 1'b0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check_eq("t3_start_spacing", last_start - prev_start, 20);

        // Reset during SHIFT aborts the word; the aborted entry is withdrawn from the scoreboard
        bus.data0 = 16'h1234;
        bus.req0  = 1'b1;
        push(1'b0, 16'h1234, 1'b0);
        repeat (6) tick();
        check_eq("t4_busy_mid", bus.busy, 1);
        saved = n_latch;
        rstn = 1'b0;
        #1;
        check_eq("t4_async_start", bus.p2s_start, 0);
        check_eq("t4_async_latch", bus.p2s_latch, 0);
        check_eq("t4_async_acks", {bus.ack0, bus.ack1}, 0);
        check_eq("t4_async_busy", bus.busy, 0);
        check_eq("t4_async_data", bus.p2s_data, 0);
        check_eq("t4_async_owner", bus.owner, 1);
        bus.req0 = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rstn = 1'b1;
        repeat (2) tick();
        check_eq("t4_no_latch", n_latch, saved);
        c = cyc;
        bus.data1 = 16'hBEEF;
        bus.req1  = 1'b1;
        push(1'b1, 16'hBEEF, 1'b0);
        wait_latches(n_latch + 1, 40, 1'b1);
        check_eq("t4_start_cycle", last_start - c, 1);
        check_eq("t4_latch_cycle", last_latch - c, 19);

        // req1 pulsed while busy and dropped before IDLE: never served
        saved = n_ack1;
        c = n_start;
        bus.data0 = 16'h5555;
        bus.req0  = 1'b1;
        push(1'b0, 16'h5555, 1'b0);
        repeat (5) tick();
        bus.data1 = 16'h6666;
        bus.req1  = 1'b1;
        tick();
        bus.req1 = 1'b0;
        wait_latches(n_latch + 1, 40, 1'b1);
        repeat (8) tick();
        check_eq("t5_ack1_count", n_ack1, saved);
        check_eq("t5_start_count", n_start - c, 1);

        // Refresh of the last word
        bus.data0 = 16'h0F0F;
        bus.req0  = 1'b1;
        push(1'b0, 16'h0F0F, 1'b0);
        wait_latches(n_latch + 1, 40, 1'b1);
`ifdef P2S_ARB_REFRESH_EN
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 16'h0F0F, 1'b1);
            wait_latches(n_latch + 1, 60, 1'b0);
            check_eq("t6_refresh_period", last_start - prev_start, 40);
        end
`else
        saved = n_start;
        repeat (100) tick();
        check_eq("t6_no_refresh", n_start, saved);
        check_eq("t6_idle_busy", bus.busy, 0);
`endif
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
